sort_scheduler: RTL and testbench
=================================

# sort_scheduler

Job scheduler between the UART receive buffer and the bitonic sorter core. It queues complete arrays that arrive as back-to-back bursts from the receive buffer and issues them to the sorter one at a time. It captures each sorted result and serialises it into bytes for the UART transmitter using a valid/ready handshake. Only one sort job is ever in flight.

## Interface
- WIDTH, 32, bits per array element
- DEPTH, 8, elements per array (power of two)
- NUM_SEQ, 10, job-queue capacity in arrays (matches the receive-buffer burst length)
- TIMEOUT, 1024, watchdog limit in cycles; used only when SORT_SCHED_WATCHDOG_EN is defined
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  one-cycle pulse; in_array holds a complete array
- in_array  in  WIDTH x DEPTH  unpacked array of DEPTH elements
- sort_start  out  1  one-cycle issue pulse to the sorter
- sort_array  out  WIDTH x DEPTH  array being issued; valid while sort_start=1
- sort_done  in  1  one-cycle pulse from the sorter; sort_result is valid in the same cycle
- sort_result  in  WIDTH x DEPTH  sorted array
- tx_valid  out  1  tx_byte is valid
- tx_byte  out  8  serialised output byte
- tx_ready  in  1  transmitter accepts tx_byte
- busy  out  1  high when the FSM is not in IDLE or the queue is non-empty
- overflow  out  1  sticky flag: an input array was dropped
- timeout_err  out  1  sticky flag: a sort job was abandoned (tied to 0 when the watchdog is compiled out)

## Operation
- Job queue: circular FIFO of NUM_SEQ arrays.
  - Write and read pointers wrap from NUM_SEQ-1 to 0.
  - Occupancy count is $clog2(NUM_SEQ+1) bits wide.
- Push: occurs on in_valid when the count is below NUM_SEQ, or when a pop happens in the same cycle.
  - Otherwise the array is dropped and overflow is set.
  - No backpressure is applied to the input.
- FSM states and transitions:
  - IDLE: if the count is non-zero, go to ISSUE.
  - ISSUE: sort_start=1 and sort_array=queue head; pop the head; go to WAIT.
  - WAIT: on sort_done, capture sort_result into the result register and go to SEND.
  - SEND: tx_valid=1. Each tx_valid&&tx_ready handshake advances the byte index. After the handshake on index DEPTH*4-1, go to IDLE.
- Serialisation order:
  - Element 0 first; within each element, least-significant byte first.
  - tx_byte = result[idx/4][8*(idx%4) +: 8]. This is the same byte order the receive path uses for assembly.
- sort_done is ignored in every state except WAIT.
- tx_byte and the byte index hold steady while tx_valid=1 and tx_ready=0.
- in_valid is accepted in every state, including SEND and WAIT.
- Reset mid-operation: the FSM returns to IDLE, the queue is emptied, and any in-flight job and partially sent result are discarded.

## Timing
- Reset values:
  - sort_start=0, sort_array='0, tx_valid=0, tx_byte=0
  - busy=0, overflow=0, timeout_err=0
  - Queue count, pointers and byte index all 0.
- All outputs are registered or decoded from state registers only. No combinational path from any input to any output.
- Latencies:
  - in_valid in cycle t into an idle, empty scheduler: sort_start is asserted in cycle t+2.
  - sort_done in cycle u: the first tx_valid appears in cycle u+1.
  - Last tx handshake in cycle v: the next sort_start comes no earlier than cycle v+2.
- Throughput: one handshake (byte) per cycle when tx_ready is held at 1, so an array takes DEPTH*4 cycles in SEND.

## Configuration
- SORT_SCHED_WATCHDOG_EN defined:
  - A cycle counter runs while in WAIT.
  - If it reaches TIMEOUT without sort_done, the job is discarded, timeout_err is set, and the FSM returns to IDLE.
  - A sort_done in the same cycle as the timeout wins: the result is captured.
- SORT_SCHED_WATCHDOG_EN undefined: no counter is built, WAIT lasts indefinitely, and timeout_err is tied to 0.

## Test plan
- Single job:
  - Stimulus: in_valid with in_array = {8,7,6,5,4,3,2,1}; sorter model returns {1..8} 3 cycles after start; tx_ready=1.
  - Required: sort_start at t+2, then 32 bytes 01 00 00 00 02 00 00 00 ... 08 00 00 00, then busy=0.
- Burst of 10:
  - Stimulus: 10 back-to-back in_valid pulses with distinct arrays.
  - Required: all 10 arrays are issued in arrival order, no overflow, 320 bytes are emitted.
- Overflow:
  - Stimulus: 12 back-to-back pulses while the sorter stalls the first job.
  - Required: overflow=1; arrays 0-10 are processed (the first was popped, so the queue held 10 more); array 11 is dropped.
- Backpressure:
  - Stimulus: toggle tx_ready 1,0,0,1 during SEND.
  - Required: tx_byte is stable while stalled; no bytes are skipped or duplicated.
- Reset mid-SEND:
  - Stimulus: assert rst after byte 5.
  - Required: next cycle tx_valid=0, busy=0; a new job afterwards starts from byte 0.
- Watchdog (with SORT_SCHED_WATCHDOG_EN, TIMEOUT=16):
  - Stimulus: the sorter never responds.
  - Required: timeout_err=1 sixteen cycles into WAIT; the queued next job then issues normally.

Source files
------------

// File: rtl/sort_scheduler_if.sv
// rtl/sort_scheduler_if.sv - handshake bundle between receive buffer, sorter core and UART transmitter
interface sort_scheduler_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  // receive buffer -> scheduler
  logic             in_valid;
  logic [WIDTH-1:0] in_array [DEPTH];
  // scheduler <-> sorter core
  logic             sort_start;
  logic [WIDTH-1:0] sort_array [DEPTH];
  logic             sort_done;
  logic [WIDTH-1:0] sort_result [DEPTH];
  // scheduler -> UART transmitter
  logic             tx_valid;
  logic [7:0]       tx_byte;
  logic             tx_ready;

  // scheduler side
  modport master (
    input  in_valid, in_array, sort_done, sort_result, tx_ready,
    output sort_start, sort_array, tx_valid, tx_byte
  );

  // environment side (receive buffer, sorter, transmitter)
  modport slave (
    output in_valid, in_array, sort_done, sort_result, tx_ready,
    input  sort_start, sort_array, tx_valid, tx_byte
  );
endinterface

// File: rtl/sort_scheduler.sv
// rtl/sort_scheduler.sv - job queue and single-job issue/serialise FSM for the bitonic sorter (optional watchdog: SORT_SCHED_WATCHDOG_EN)
module sort_scheduler #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int NUM_SEQ = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  sort_scheduler_if.master  bus,
  output logic              busy,
  output logic              overflow,
  output logic              timeout_err
);

  localparam int PW = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1;
  localparam int CW = $clog2(NUM_SEQ + 1);
  localparam int NB = DEPTH * 4;
  localparam int IW = $clog2(NB);
  localparam logic [CW-1:0] FULL    = CW'(NUM_SEQ);
  localparam logic [PW-1:0] LAST    = PW'(NUM_SEQ - 1);
  localparam logic [IW-1:0] IDX_END = IW'(NB - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SEND} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mem [NUM_SEQ][DEPTH];
  logic [WIDTH-1:0] result [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [IW-1:0]    idx;
  logic             push, pop, load_issue, capture, advance, timed_out;

  // A pop in the same cycle frees a slot, so a full queue still accepts then
  assign push = bus.in_valid && ((count != FULL) || pop);
  assign busy = (state != IDLE) || (count != '0);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state, datapath strobes and state-decoded outputs
  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    load_issue     = 1'b0;
    capture        = 1'b0;
    advance        = 1'b0;
    bus.sort_start = (state == ISSUE);
    bus.tx_valid   = (state == SEND);
    bus.tx_byte    = 8'h00;
    case (state)
      IDLE: begin
        if (count != '0) begin
          load_issue = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        pop        = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.sort_done) begin
          capture    = 1'b1;
          state_next = SEND;
        end else if (timed_out) begin
          state_next = IDLE;
        end
      end
      SEND: begin
        bus.tx_byte = result[idx[IW-1:2]][{idx[1:0], 3'b000} +: 8];
        if (bus.tx_ready) begin
          advance = 1'b1;
          if (idx == IDX_END) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Circular job queue with drop-and-flag on overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.in_array;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.in_valid && !push) overflow <= 1'b1;
    end
  end

  // Issue register (loaded on the way into ISSUE) and sorted-result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        bus.sort_array[e] <= '0;
        result[e]         <= '0;
      end
    end else begin
      if (load_issue) bus.sort_array <= mem[rd_ptr];
      if (capture)    result         <= bus.sort_result;
    end
  end

  // Byte index: restarts on every issue, wraps naturally after the last byte
  always_ff @(posedge clk) begin
    if (rst || state == ISSUE) idx <= '0;
    else if (advance)          idx <= idx + 1'b1;
  end

`ifdef SORT_SCHED_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt;

  assign timed_out = (state == WAIT) && (wd_cnt == WDW'(TIMEOUT - 1));

  // Watchdog: counts WAIT cycles; a same-cycle sort_done beats the timeout
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wd_cnt <= '0;
    else                      wd_cnt <= wd_cnt + 1'b1;
  end

  // Sticky abandoned-job flag
  always_ff @(posedge clk) begin
    if (rst)                               timeout_err <= 1'b0;
    else if (timed_out && !bus.sort_done)  timeout_err <= 1'b1;
  end
`else
  // No watchdog: WAIT lasts until the sorter answers and the flag stays low
  assign timed_out   = 1'b0;
  assign timeout_err = 1'b0 & (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_sort_scheduler.sv
// tb/tb_sort_scheduler.sv - randomized self-checking bench for sort_scheduler
module tb_sort_scheduler;
  localparam int WIDTH = 32, DEPTH = 8, NUM_SEQ = 10, TIMEOUT = 16, NB = DEPTH * 4;
  typedef logic [DEPTH-1:0][WIDTH-1:0] arr_t;

  logic clk = 1'b0;
  logic rst;
  logic busy, overflow, timeout_err;

  sort_scheduler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sort_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_SEQ(NUM_SEQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model and logs
  arr_t        gen[$];
  arr_t        exp_q[$];
  arr_t        issued_q[$];
  int          issue_cyc[$];
  logic [7:0]  rx_q[$];
  int          rx_cyc[$];
  int          done_cyc[$];
  int          model_cnt = 0;
  int          model_drops = 0;
  int          stall_changes = 0;
  int          gap_violations = 0;
  int          last_tx_cyc = -10;
  bit          prev_stall = 0;
  logic [7:0]  prev_byte = 0;

  int          sort_delay = 3;
  bit          sorter_stall = 0;
  int          ready_mode = 0;

  function automatic arr_t sort_arr(input arr_t a);
    arr_t r = a;
    logic [WIDTH-1:0] t;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH - 1 - i; j++)
        if (r[j] > r[j+1]) begin t = r[j]; r[j] = r[j+1]; r[j+1] = t; end
    return r;
  endfunction

  function automatic logic [7:0] ser_byte(input arr_t a, input int k);
    return a[k/4][8*(k%4) +: 8];
  endfunction

  // Monitor: queue admission model, issue log, handshake log, stall stability
  always @(negedge clk) begin
    arr_t a;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (bus.sort_start) begin
        for (int e = 0; e < DEPTH; e++) a[e] = bus.sort_array[e];
        issued_q.push_back(a);
        issue_cyc.push_back(cyc);
        if (cyc < last_tx_cyc + 2) gap_violations++;
        model_cnt--;
      end
      if (bus.in_valid) begin
        if (model_cnt < NUM_SEQ) begin
          for (int e = 0; e < DEPTH; e++) a[e] = bus.in_array[e];
          exp_q.push_back(a);
          model_cnt++;
        end else begin
          model_drops++;
        end
      end
      if (prev_stall && (!bus.tx_valid || bus.tx_byte !== prev_byte)) stall_changes++;
      if (bus.tx_valid && bus.tx_ready) begin
        rx_q.push_back(bus.tx_byte);
        rx_cyc.push_back(cyc);
        last_tx_cyc = cyc;
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_byte  = bus.tx_byte;
    end
  end

  // Sorter model: answers sort_delay cycles after sort_start (0 = never)
  initial begin
    arr_t job, srt;
    int   timer = 0;
    bus.sort_done = 0;
    for (int e = 0; e < DEPTH; e++) bus.sort_result[e] = '0;
    forever begin
      @(posedge clk); #1;
      bus.sort_done = 0;
      if (rst) begin
        timer = 0;
      end else begin
        if (timer > 0 && !sorter_stall) begin
          timer--;
          if (timer == 0) begin
            srt = sort_arr(job);
            for (int e = 0; e < DEPTH; e++) bus.sort_result[e] = srt[e];
            bus.sort_done = 1;
            done_cyc.push_back(cyc);
          end
        end
        if (bus.sort_start) begin
          for (int e = 0; e < DEPTH; e++) job[e] = bus.sort_array[e];
          timer = sort_delay;
        end
      end
    end
  end

  // Transmitter model: always ready, 1,0,0,1 pattern, or random
  initial begin
    int k = 0;
    bus.tx_ready = 1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       bus.tx_ready = (k % 4 == 0) || (k % 4 == 3);
        2:       bus.tx_ready = 1'($urandom_range(0, 1));
        default: bus.tx_ready = 1;
      endcase
      k++;
    end
  end

  task automatic clear_logs();
    gen.delete(); exp_q.delete(); issued_q.delete(); issue_cyc.delete();
    rx_q.delete(); rx_cyc.delete(); done_cyc.delete();
    model_drops = 0; stall_changes = 0; gap_violations = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1; bus.in_valid = 0;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    model_cnt = 0;
    clear_logs();
  endtask

  task automatic drive_array(input arr_t a);
    @(posedge clk); #2;
    bus.in_valid = 1;
    for (int e = 0; e < DEPTH; e++) bus.in_array[e] = a[e];
  endtask

  task automatic send_burst(input int n, input int gap);
    arr_t a;
    for (int i = 0; i < n; i++) begin
      for (int e = 0; e < DEPTH; e++) a[e] = $urandom;
      gen.push_back(a);
      drive_array(a);
      if (gap > 0) begin
        @(posedge clk); #2 bus.in_valid = 0;
        repeat (gap - 1) @(posedge clk);
      end
    end
    @(posedge clk); #2 bus.in_valid = 0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    arr_t sa;
    do_reset();
    @(negedge clk);
    for (int e = 0; e < DEPTH; e++) sa[e] = bus.sort_array[e];
    checks++; if (bus.sort_start !== 1'b0) begin errors++; $display("FAIL reset_sort_start: got %b expected 0", bus.sort_start); end
    checks++; if (sa !== '0) begin errors++; $display("FAIL reset_sort_array: got %h expected 0", sa); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", bus.tx_valid); end
    checks++; if (bus.tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %h expected 00", bus.tx_byte); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
  endtask

  task automatic test_single();
    arr_t a;
    int   t, bad;
    bit   ok;
    clear_logs(); ready_mode = 0; sort_delay = 3;
    for (int e = 0; e < DEPTH; e++) a[e] = WIDTH'(DEPTH - e);
    drive_array(a);
    t = cyc;
    @(posedge clk); #2 bus.in_valid = 0;
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle: busy still %b after 300 cycles, expected 0", busy); end
    checks++; if (issue_cyc.size() != 1 || issue_cyc[0] != t + 2) begin errors++; $display("FAIL single_start_cycle: got %0d issues first at %0d expected 1 at %0d", issue_cyc.size(), (issue_cyc.size() > 0) ? issue_cyc[0] : -1, t + 2); end
    checks++; if (issued_q.size() < 1 || issued_q[0] !== a) begin errors++; $display("FAIL single_issue_array: got %h expected %h", (issued_q.size() > 0) ? issued_q[0] : '0, a); end
    checks++; if (rx_q.size() != NB) begin errors++; $display("FAIL single_byte_count: got %0d expected %0d", rx_q.size(), NB); end
    bad = 0;
    for (int k = 0; k < NB && k < rx_q.size(); k++)
      if (rx_q[k] !== ((k % 4 == 0) ? 8'(k / 4 + 1) : 8'h00)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL single_bytes: got %0d wrong bytes expected 0", bad); end
    checks++; if (done_cyc.size() < 1 || rx_cyc.size() < 1 || rx_cyc[0] != done_cyc[0] + 1) begin errors++; $display("FAIL single_tx_latency: got first tx %0d expected %0d", (rx_cyc.size() > 0) ? rx_cyc[0] : -1, (done_cyc.size() > 0) ? done_cyc[0] + 1 : -1); end
    checks++; if (rx_cyc.size() != NB || rx_cyc[NB-1] - rx_cyc[0] != NB - 1) begin errors++; $display("FAIL single_throughput: got span %0d expected %0d", (rx_cyc.size() == NB) ? rx_cyc[NB-1] - rx_cyc[0] : -1, NB - 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_burst();
    bit ok;
    int bad;
    clear_logs(); ready_mode = 0; sort_delay = $urandom_range(1, 6);
    send_burst(NUM_SEQ, 0);
    wait_idle(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_idle: busy still %b expected 0", busy); end
    checks++; if (overflow !== 1'b0 || model_drops != 0) begin errors++; $display("FAIL burst_overflow: got %b expected 0", overflow); end
    checks++; if (issued_q.size() != NUM_SEQ) begin errors++; $display("FAIL burst_issue_count: got %0d expected %0d", issued_q.size(), NUM_SEQ); end
    bad = 0;
    for (int j = 0; j < NUM_SEQ && j < issued_q.size(); j++) if (issued_q[j] !== gen[j]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL burst_issue_order: got %0d misordered arrays expected 0", bad); end
    checks++; if (rx_q.size() != NUM_SEQ * NB) begin errors++; $display("FAIL burst_byte_count: got %0d expected %0d", rx_q.size(), NUM_SEQ * NB); end
    bad = 0;
    for (int k = 0; k < rx_q.size() && k < NUM_SEQ * NB; k++) if (rx_q[k] !== ser_byte(sort_arr(gen[k / NB]), k % NB)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL burst_bytes: got %0d wrong bytes expected 0", bad); end
    checks++; if (gap_violations != 0) begin errors++; $display("FAIL burst_issue_gap: got %0d early issues expected 0", gap_violations); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    for (int mode = 1; mode <= 2; mode++) begin
      clear_logs(); ready_mode = mode; sort_delay = $urandom_range(1, 4);
      send_burst(3, $urandom_range(1, 5));
      wait_idle(3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_idle mode %0d: busy still %b expected 0", mode, busy); end
      checks++; if (rx_q.size() != exp_q.size() * NB || exp_q.size() != 3) begin errors++; $display("FAIL bp_byte_count mode %0d: got %0d expected %0d", mode, rx_q.size(), 3 * NB); end
      bad = 0;
      for (int k = 0; k < rx_q.size() && k < exp_q.size() * NB; k++) if (rx_q[k] !== ser_byte(sort_arr(exp_q[k / NB]), k % NB)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_bytes mode %0d: got %0d wrong bytes expected 0", mode, bad); end
      checks++; if (stall_changes != 0) begin errors++; $display("FAIL bp_stall_stable mode %0d: got %0d changes expected 0", mode, stall_changes); end
    end
    ready_mode = 0;
  endtask

  task automatic test_overflow();
    bit ok;
    int bad;
    clear_logs(); ready_mode = 0; sort_delay = 1; sorter_stall = 1;
    send_burst(NUM_SEQ + 2, 0);
    sorter_stall = 0;
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    wait_idle(4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_idle: busy still %b expected 0", busy); end
    checks++; if (model_drops != 1 || exp_q.size() != NUM_SEQ + 1 || exp_q[NUM_SEQ] !== gen[NUM_SEQ]) begin errors++; $display("FAIL ovf_model: got %0d drops expected 1", model_drops); end
    checks++; if (issued_q.size() != NUM_SEQ + 1) begin errors++; $display("FAIL ovf_issue_count: got %0d expected %0d", issued_q.size(), NUM_SEQ + 1); end
    bad = 0;
    for (int j = 0; j < issued_q.size() && j <= NUM_SEQ; j++) if (issued_q[j] !== gen[j]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ovf_issue_order: got %0d wrong arrays expected 0", bad); end
    bad = 0;
    for (int k = 0; k < rx_q.size() && k < (NUM_SEQ + 1) * NB; k++) if (rx_q[k] !== ser_byte(sort_arr(gen[k / NB]), k % NB)) bad++;
    checks++; if (bad != 0 || rx_q.size() != (NUM_SEQ + 1) * NB) begin errors++; $display("FAIL ovf_bytes: got %0d bytes %0d wrong expected %0d bytes 0 wrong", rx_q.size(), bad, (NUM_SEQ + 1) * NB); end
    do_reset();
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b expected 0", overflow); end
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    int bad;
    clear_logs(); ready_mode = 0; sort_delay = 2;
    send_burst(1, 0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_q.size() >= 5) begin ok = 1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_send_progress: got %0d bytes expected 5", rx_q.size()); end
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    model_cnt = 0;
    @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_send_tx_valid: got %b expected 0", bus.tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_send_busy: got %b expected 0", busy); end
    clear_logs();
    send_burst(1, 0);
    wait_idle(300, ok);
    bad = 0;
    for (int k = 0; k < rx_q.size() && k < NB; k++) if (rx_q[k] !== ser_byte(sort_arr(gen[0]), k)) bad++;
    checks++; if (!ok || bad != 0 || rx_q.size() != NB) begin errors++; $display("FAIL rst_send_restart: got %0d bytes %0d wrong expected %0d bytes 0 wrong", rx_q.size(), bad, NB); end
  endtask

  task automatic test_watchdog();
    bit ok;
    int s, bad;
`ifdef SORT_SCHED_WATCHDOG_EN
    clear_logs(); ready_mode = 0; sort_delay = 0;
    send_burst(2, 0);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (issue_cyc.size() > 0) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL wd_first_issue: got %0d issues expected 1", issue_cyc.size()); end
    s = (issue_cyc.size() > 0) ? issue_cyc[0] : cyc;
    @(negedge clk);
    while (cyc < s + 16) @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_early: got %b expected 0 at cycle %0d", timeout_err, cyc); end
    sort_delay = 3;
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_timeout_err: got %b expected 1 at cycle %0d", timeout_err, cyc); end
    wait_idle(300, ok);
    checks++; if (issue_cyc.size() != 2 || issue_cyc[1] != s + 18) begin errors++; $display("FAIL wd_next_issue: got %0d issues second at %0d expected 2 at %0d", issue_cyc.size(), (issue_cyc.size() > 1) ? issue_cyc[1] : -1, s + 18); end
    bad = 0;
    for (int k = 0; k < rx_q.size() && k < NB; k++) if (rx_q[k] !== ser_byte(sort_arr(gen[1]), k)) bad++;
    checks++; if (!ok || bad != 0 || rx_q.size() != NB) begin errors++; $display("FAIL wd_next_bytes: got %0d bytes %0d wrong expected %0d bytes 0 wrong", rx_q.size(), bad, NB); end
`else
    clear_logs(); ready_mode = 0; sort_delay = 0;
    send_burst(1, 0);
    repeat (3 * TIMEOUT) @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_off_flag: got %b expected 0", timeout_err); end
    checks++; if (busy !== 1'b1 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL wd_off_wait: got busy %b tx_valid %b expected 1 0", busy, bus.tx_valid); end
`endif
    do_reset();
    sort_delay = 3;
  endtask

  initial begin
    rst = 1;
    bus.in_valid = 0;
    for (int e = 0; e < DEPTH; e++) bus.in_array[e] = '0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_overflow();
    test_reset_mid_send();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
